// File: rtl/video_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : video_blend_pipe
// Function : three-stage compositor of playfield B over playfield A with a
//            per-line mode (overlay, alpha blend, additive clamp, A only).
// Revision : 1.0 - initial release
// ============================================================================
module video_blend_pipe #(
   parameter int CHAN_W            = 4,
   parameter int ALPHA_W           = 4,
   parameter int EN_BLEND          = 1,
   parameter int EN_BLEND_ADDCLAMP = 1
) (
   input  logic                        clk,
   input  logic                        reset_i,
   input  logic [1:0]                  blend_mode_i,
   input  logic                        vsync_i,
   input  logic                        hsync_i,
   input  logic                        dv_de_i,
   input  logic [ALPHA_W+3*CHAN_W-1:0] colorA_xrgb_i,
   input  logic [ALPHA_W+3*CHAN_W-1:0] colorB_xrgb_i,
   output logic [3*CHAN_W-1:0]         blend_rgb_o,
   output logic                        hsync_o,
   output logic                        vsync_o,
   output logic                        dv_de_o
);

   localparam int c_PIX_W    = ALPHA_W + 3*CHAN_W;
   localparam int c_RGB_W    = 3*CHAN_W;
   localparam int c_ALPHA_W1 = ALPHA_W + 1;
   localparam int c_PROD_W   = CHAN_W + ALPHA_W + 1;
   localparam int c_SUM_W    = CHAN_W + ALPHA_W + 2;

   localparam logic [1:0] c_MODE_OVERLAY = 2'd0;
   localparam logic [1:0] c_MODE_ALPHA   = 2'd1;
   localparam logic [1:0] c_MODE_ADD     = 2'd2;
   localparam logic [1:0] c_MODE_AONLY   = 2'd3;

   localparam logic [c_SUM_W-1:0]  c_CHAN_MAX   = c_SUM_W'((1 << CHAN_W) - 1);
   localparam logic [ALPHA_W:0]    c_ALPHA_ONE  = c_ALPHA_W1'(1);
   localparam logic [ALPHA_W:0]    c_ALPHA_FULL = {1'b1, {ALPHA_W{1'b0}}};

   logic               r_hsync_prev;
   logic [1:0]         r_active_mode;
   logic [1:0]         w_req_mode;
   logic [1:0]         w_next_mode;
   logic               w_line_start;

   logic [c_RGB_W-1:0] r_s1_a;
   logic [c_PIX_W-1:0] r_s1_b;
   logic [1:0]         r_s1_mode;
   logic               r_s1_hs, r_s1_vs, r_s1_de;

   logic [1:0]         r_s2_mode;
   logic               r_s2_hs, r_s2_vs, r_s2_de;

   logic [ALPHA_W-1:0] w_fa;
   logic [ALPHA_W:0]   w_alpha;
   logic [ALPHA_W:0]   w_inv;
   logic [c_RGB_W-1:0] w_rgb3;

   // Alpha of the bottom playfield carries no meaning here.
   logic w_unused_a_alpha;
   assign w_unused_a_alpha = ^colorA_xrgb_i[c_PIX_W-1 -: ALPHA_W];

   always_comb begin
      w_req_mode = blend_mode_i;
      if ((blend_mode_i == c_MODE_ALPHA && EN_BLEND == 0) ||
          (blend_mode_i == c_MODE_ADD && EN_BLEND_ADDCLAMP == 0))
         w_req_mode = c_MODE_OVERLAY;
   end

   assign w_line_start = hsync_i & ~r_hsync_prev;
   assign w_next_mode  = w_line_start ? w_req_mode : r_active_mode;

   assign w_fa    = r_s1_b[c_PIX_W-1 -: ALPHA_W];
   assign w_alpha = {1'b0, w_fa} + c_ALPHA_ONE;
   assign w_inv   = c_ALPHA_FULL - {1'b0, w_fa};

   // hsync_prev comes out of reset high so a level held across release is not a line start.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_hsync_prev  <= 1'b1;
         r_active_mode <= c_MODE_OVERLAY;
         r_s1_a        <= '0;
         r_s1_b        <= '0;
         r_s1_mode     <= c_MODE_OVERLAY;
         r_s1_hs       <= 1'b0;
         r_s1_vs       <= 1'b0;
         r_s1_de       <= 1'b0;
         r_s2_mode     <= c_MODE_OVERLAY;
         r_s2_hs       <= 1'b0;
         r_s2_vs       <= 1'b0;
         r_s2_de       <= 1'b0;
         blend_rgb_o   <= '0;
         hsync_o       <= 1'b0;
         vsync_o       <= 1'b0;
         dv_de_o       <= 1'b0;
      end else begin
         r_hsync_prev  <= hsync_i;
         r_active_mode <= w_next_mode;
         r_s1_a        <= colorA_xrgb_i[c_RGB_W-1:0];
         r_s1_b        <= colorB_xrgb_i;
         r_s1_mode     <= w_next_mode;
         r_s1_hs       <= hsync_i;
         r_s1_vs       <= vsync_i;
         r_s1_de       <= dv_de_i;
         r_s2_mode     <= r_s1_mode;
         r_s2_hs       <= r_s1_hs;
         r_s2_vs       <= r_s1_vs;
         r_s2_de       <= r_s1_de;
         blend_rgb_o   <= r_s2_de ? w_rgb3 : '0;
         hsync_o       <= r_s2_hs;
         vsync_o       <= r_s2_vs;
         dv_de_o       <= r_s2_de;
      end
   end

   generate
      for (genvar ch = 0; ch < 3; ch++) begin : g_chan
         logic [CHAN_W-1:0]  w_a, w_b;
         logic [c_SUM_W-1:0] w_blend, w_add, w_s2_val, r_s2_val, w_pre;

         assign w_a = r_s1_a[ch*CHAN_W +: CHAN_W];
         assign w_b = r_s1_b[ch*CHAN_W +: CHAN_W];

         if (EN_BLEND != 0) begin : g_blend
            logic [c_PROD_W-1:0] w_prod_fg, w_prod_bg;
            assign w_prod_fg = c_PROD_W'(w_alpha) * c_PROD_W'(w_b);
            assign w_prod_bg = c_PROD_W'(w_inv) * c_PROD_W'(w_a);
            assign w_blend   = c_SUM_W'(w_prod_fg) + c_SUM_W'(w_prod_bg);
         end else begin : g_no_blend
            assign w_blend = '0;
         end

         if (EN_BLEND_ADDCLAMP != 0) begin : g_add
            assign w_add = c_SUM_W'(w_a) + c_SUM_W'(w_b);
         end else begin : g_no_add
            assign w_add = '0;
         end

         always_comb begin
            case (r_s1_mode)
               c_MODE_ALPHA: w_s2_val = w_blend;
               c_MODE_ADD:   w_s2_val = w_add;
               c_MODE_AONLY: w_s2_val = c_SUM_W'(w_a);
               default:      w_s2_val = (w_fa != '0) ? c_SUM_W'(w_b) : c_SUM_W'(w_a);
            endcase
         end

         always_ff @(posedge clk or posedge reset_i) begin
            if (reset_i) r_s2_val <= '0;
            else         r_s2_val <= w_s2_val;
         end

         // Only the blend sum needs scaling; the clamp is a no-op for overlay and A-only.
         assign w_pre = (r_s2_mode == c_MODE_ALPHA) ? (r_s2_val >> ALPHA_W) : r_s2_val;
         assign w_rgb3[ch*CHAN_W +: CHAN_W] =
            (w_pre > c_CHAN_MAX) ? c_CHAN_MAX[CHAN_W-1:0] : w_pre[CHAN_W-1:0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_video_blend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_blend_pipe
// Function : self-checking bench for video_blend_pipe (full and no-blend builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_blend_pipe;

   localparam int CW     = 4;
   localparam int AW     = 4;
   localparam int MAXV   = (1 << CW) - 1;
   localparam int ASCALE = 1 << AW;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [1:0]  blend_mode_i;
   logic        vsync_i, hsync_i, dv_de_i;
   logic [15:0] colorA, colorB;
   logic [11:0] blend_rgb_o, nb_rgb;
   logic        hsync_o, vsync_o, dv_de_o, nb_hs, nb_vs, nb_de;
   logic [29:0] outs;

   int tests = 0;
   int fails = 0;
   int m_mode;
   logic m_prev;
   logic [29:0] q[$];

   always #5 clk = ~clk;

   video_blend_pipe #(.CHAN_W(CW), .ALPHA_W(AW), .EN_BLEND(1), .EN_BLEND_ADDCLAMP(1)) dut (
      .clk(clk), .reset_i(reset_i), .blend_mode_i(blend_mode_i), .vsync_i(vsync_i),
      .hsync_i(hsync_i), .dv_de_i(dv_de_i), .colorA_xrgb_i(colorA), .colorB_xrgb_i(colorB),
      .blend_rgb_o(blend_rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .dv_de_o(dv_de_o));

   video_blend_pipe #(.CHAN_W(CW), .ALPHA_W(AW), .EN_BLEND(0), .EN_BLEND_ADDCLAMP(1)) dut_nb (
      .clk(clk), .reset_i(reset_i), .blend_mode_i(blend_mode_i), .vsync_i(vsync_i),
      .hsync_i(hsync_i), .dv_de_i(dv_de_i), .colorA_xrgb_i(colorA), .colorB_xrgb_i(colorB),
      .blend_rgb_o(nb_rgb), .hsync_o(nb_hs), .vsync_o(nb_vs), .dv_de_o(nb_de));

   assign outs = {blend_rgb_o, nb_rgb, hsync_o, vsync_o, dv_de_o, nb_hs, nb_vs, nb_de};

   typedef struct {
      logic [1:0]  mode;
      logic        de;
      logic [15:0] a;
      logic [15:0] b;
      logic [11:0] exp;
      logic [11:0] exp_nb;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Composite of one pixel straight from the mode rules, integer arithmetic per channel.
   function automatic logic [11:0] ref_rgb(input int mode, input logic [15:0] a,
                                           input logic [15:0] b, input logic de);
      int fa, av, bv, v;
      logic [11:0] r;
      r  = '0;
      fa = int'(b[15:12]);
      if (!de) return '0;
      for (int c = 0; c < 3; c++) begin
         av = int'((a >> (4*c)) & 16'hF);
         bv = int'((b >> (4*c)) & 16'hF);
         case (mode)
            0:       v = (fa != 0) ? bv : av;
            1:       v = ((fa + 1) * bv + (ASCALE - fa) * av) / ASCALE;
            2:       v = av + bv;
            default: v = av;
         endcase
         if (v > MAXV) v = MAXV;
         r = r | 12'(v << (4*c));
      end
      return r;
   endfunction

   task automatic cycle();
      logic [29:0] e;
      if (hsync_i && !m_prev) m_mode = int'(blend_mode_i);
      m_prev = hsync_i;
      e = {ref_rgb(m_mode, colorA, colorB, dv_de_i),
           ref_rgb((m_mode == 1) ? 0 : m_mode, colorA, colorB, dv_de_i),
           hsync_i, vsync_i, dv_de_i, hsync_i, vsync_i, dv_de_i};
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 3) begin
         e = q.pop_front();
         check("pipe", 32'(outs), 32'(e));
      end
   endtask

   task automatic set_px(input int mode, input logic hs, input logic de,
                         input logic [15:0] a, input logic [15:0] b);
      blend_mode_i = 2'(mode);
      hsync_i      = hs;
      vsync_i      = 1'b0;
      dv_de_i      = de;
      colorA       = a;
      colorB       = b;
   endtask

   task automatic do_reset(input logic hs_hold);
      reset_i = 1'b1;
      #1;
      check("reset_async", 32'(outs), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         colorA       = 16'($urandom);
         colorB       = 16'($urandom);
         dv_de_i      = 1'($urandom);
         vsync_i      = 1'($urandom);
         hsync_i      = 1'($urandom);
         blend_mode_i = 2'($urandom);
         #1;
         check("reset_hold", 32'(outs), 32'd0);
      end
      @(posedge clk);
      #1;
      set_px(2, hs_hold, 1'b0, 16'h0, 16'h0);
      reset_i = 1'b0;
      q.delete();
      q.push_back('0);
      q.push_back('0);
      m_prev = 1'b1;
      m_mode = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'd1, 1'b1, 16'h00F0, 16'h8F00, 12'h870, 12'hF00};
      tbl[1] = '{2'd1, 1'b1, 16'h0000, 16'hFF00, 12'hF00, 12'hF00};
      tbl[2] = '{2'd1, 1'b1, 16'h00F0, 16'h0000, 12'h0F0, 12'h0F0};
      tbl[3] = '{2'd2, 1'b1, 16'h0C84, 16'hF6A9, 12'hFFD, 12'hFFD};
      tbl[4] = '{2'd2, 1'b1, 16'h0123, 16'h0111, 12'h234, 12'h234};
      tbl[5] = '{2'd0, 1'b1, 16'h0123, 16'h0456, 12'h123, 12'h123};
      tbl[6] = '{2'd0, 1'b1, 16'h0123, 16'h1456, 12'h456, 12'h456};
      tbl[7] = '{2'd3, 1'b1, 16'h0123, 16'hF456, 12'h123, 12'h123};
      tbl[8] = '{2'd1, 1'b0, 16'h0FFF, 16'h8FFF, 12'h000, 12'h000};
      tbl[9] = '{2'd2, 1'b0, 16'h0FFF, 16'h8FFF, 12'h000, 12'h000};

      set_px(0, 1'b0, 1'b0, 16'h0, 16'h0);
      do_reset(1'b0);

      // dv_de step must take exactly three clocks to reach the output.
      set_px(0, 1'b0, 1'b1, 16'h0, 16'h0);
      cycle(); check("de_step_c1", 32'(dv_de_o), 32'd0);
      cycle(); check("de_step_c2", 32'(dv_de_o), 32'd0);
      cycle(); check("de_step_c3", 32'(dv_de_o), 32'd1);

      for (int i = 0; i < 10; i++) begin
         set_px(0, 1'b0, 1'b0, 16'h0, 16'h0);
         cycle();
         set_px(int'(tbl[i].mode), 1'b1, tbl[i].de, tbl[i].a, tbl[i].b);
         cycle();
         set_px(int'(tbl[i].mode), 1'b1, 1'b0, 16'h0, 16'h0);
         cycle();
         cycle();
         check($sformatf("vec%0d", i), 32'(blend_rgb_o), 32'(tbl[i].exp));
         check($sformatf("vec%0d_noblend", i), 32'(nb_rgb), 32'(tbl[i].exp_nb));
      end

      // Mode request changing mid-line must wait for the next line start.
      set_px(0, 1'b0, 1'b0, 16'h0, 16'h0);
      cycle();
      set_px(3, 1'b1, 1'b1, 16'h0123, 16'hF111);
      cycle();
      set_px(2, 1'b1, 1'b1, 16'h0123, 16'hF111);
      cycle();
      set_px(2, 1'b1, 1'b0, 16'h0, 16'h0);
      cycle();
      cycle();
      check("midline_keeps_old", 32'(blend_rgb_o), 32'h123);
      set_px(2, 1'b0, 1'b0, 16'h0, 16'h0);
      cycle();
      set_px(2, 1'b1, 1'b1, 16'h0123, 16'hF111);
      cycle();
      set_px(2, 1'b1, 1'b0, 16'h0, 16'h0);
      cycle();
      cycle();
      check("next_line_new_mode", 32'(blend_rgb_o), 32'h234);

      for (int i = 0; i < 400; i++) begin
         hsync_i      = ((i % 24) < 4);
         vsync_i      = ((i % 200) < 6);
         dv_de_i      = ((i % 24) >= 6) ? 1'($urandom) | 1'($urandom) : 1'b0;
         blend_mode_i = 2'($urandom);
         colorA       = 16'($urandom);
         colorB       = 16'($urandom);
         cycle();
      end

      // Reset mid-line with hsync held high across release: no line start until a new edge.
      do_reset(1'b1);
      set_px(2, 1'b1, 1'b1, 16'h0123, 16'h0111);
      cycle();
      set_px(2, 1'b1, 1'b0, 16'h0, 16'h0);
      cycle();
      cycle();
      check("hs_held_overlay", 32'(blend_rgb_o), 32'h123);
      set_px(2, 1'b0, 1'b0, 16'h0, 16'h0);
      cycle();
      set_px(2, 1'b1, 1'b1, 16'h0123, 16'h0111);
      cycle();
      set_px(2, 1'b1, 1'b0, 16'h0, 16'h0);
      cycle();
      cycle();
      check("hs_new_edge_add", 32'(blend_rgb_o), 32'h234);

      for (int i = 0; i < 200; i++) begin
         hsync_i      = ((i % 16) < 2);
         vsync_i      = 1'($urandom);
         dv_de_i      = 1'($urandom);
         blend_mode_i = 2'($urandom);
         colorA       = 16'($urandom);
         colorB       = 16'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
